spy_path_delay_meter: RTL and testbench

Launch-and-capture controller for the delay-chain spy paths. It drives the input of a chained path such as the 50-stage inverter chain and toggles it once per trial. It then counts clock cycles until the synchronized chain output settles to the expected value. Results over N trials are accumulated into a sum, a min and a max for readout by the host logic that sits above the spy paths.

---
 rtl/spy_path_delay_meter_pkg.sv | 18 +
 rtl/spy_path_delay_meter_sync.sv | 25 ++
 rtl/spy_path_delay_meter.sv | 142 ++++++++++++++
 tb/tb_spy_path_delay_meter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spy_path_delay_meter_pkg.sv
// Shared types and default settings for the spy-path delay meter.
package spy_meter_pkg;

  // Controller states: wait for a request, drive a transition, count until settled, report.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } meter_state_t;

  localparam int CNT_W_DEFAULT       = 12;
  localparam int TRIAL_W_DEFAULT     = 8;
  localparam int SUM_W_DEFAULT       = 20;
  localparam int TIMEOUT_DEFAULT     = 4000;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spy_path_delay_meter_sync.sv
// Multi-flop synchronizer that brings the asynchronous chain output into the clk domain.
module spy_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw input through the flop chain; reset to the idle level of the chain output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spy_path_delay_meter.sv
// Launch-and-capture controller: toggles the chain input once per trial, counts cycles
// until the synchronized chain output settles, and accumulates sum/min/max over a run.
module spy_path_delay_meter
  import spy_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int TRIAL_W     = TRIAL_W_DEFAULT,
  parameter int SUM_W       = SUM_W_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int INVERT      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TRIAL_W-1:0] trials,
  output logic               pathInput,
  input  logic               pathResult,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [SUM_W-1:0]   sum_cycles,
  output logic [CNT_W-1:0]   min_cycles,
  output logic [CNT_W-1:0]   max_cycles
);

  localparam logic             INV_BIT     = (INVERT != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  // Wide enough that adding one count to the sum can never wrap before saturation is checked.
  localparam int               ACC_W       = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;

  meter_state_t       state, state_next;
  logic [TRIAL_W-1:0] remaining, remaining_next;
  logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
  logic               path_input_next;
  logic               busy_next, done_next, timeout_next;
  logic [SUM_W-1:0]   sum_next, sum_sat;
  logic [CNT_W-1:0]   min_next, max_next;
  logic [ACC_W-1:0]   sum_wide;
  logic               sync_out, match;

  spy_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(INV_BIT)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pathResult),
    .q  (sync_out)
  );

  // Next-state and next-value logic; every register holds unless its state says otherwise.
  always_comb begin
    state_next      = state;
    remaining_next  = remaining;
    cnt_next        = cnt;
    path_input_next = pathInput;
    timeout_next    = timeout;
    sum_next        = sum_cycles;
    min_next        = min_cycles;
    max_next        = max_cycles;

    cnt_inc  = cnt + CNT_W'(1);
    match    = (sync_out == (pathInput ^ INV_BIT));
    sum_wide = ACC_W'(sum_cycles) + ACC_W'(cnt_inc);
    sum_sat  = (sum_wide > ACC_W'({SUM_W{1'b1}})) ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];

    case (state)
      IDLE: begin
        if (start) begin
          remaining_next = trials;
          sum_next       = {SUM_W{1'b0}};
          max_next       = {CNT_W{1'b0}};
          min_next       = {CNT_W{1'b1}};
          timeout_next   = 1'b0;
          state_next     = (trials == {TRIAL_W{1'b0}}) ? DONE : LAUNCH;
        end else begin
          state_next = IDLE;
        end
      end
      LAUNCH: begin
        path_input_next = ~pathInput;
        cnt_next        = {CNT_W{1'b0}};
        state_next      = WAIT;
      end
      WAIT: begin
        cnt_next = cnt_inc;
        if (match) begin
          sum_next       = sum_sat;
          min_next       = (cnt_inc < min_cycles) ? cnt_inc : min_cycles;
          max_next       = (cnt_inc > max_cycles) ? cnt_inc : max_cycles;
          remaining_next = remaining - TRIAL_W'(1);
          state_next     = (remaining == TRIAL_W'(1)) ? DONE : LAUNCH;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          // Abandon the run; the unfinished trial is not folded into the statistics.
          timeout_next = 1'b1;
          state_next   = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with the state itself.
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  // State, datapath and registered outputs; pathInput comes straight from its own flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= {TRIAL_W{1'b0}};
      cnt        <= {CNT_W{1'b0}};
      pathInput  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      sum_cycles <= {SUM_W{1'b0}};
      min_cycles <= {CNT_W{1'b1}};
      max_cycles <= {CNT_W{1'b0}};
    end else begin
      state      <= state_next;
      remaining  <= remaining_next;
      cnt        <= cnt_next;
      pathInput  <= path_input_next;
      busy       <= busy_next;
      done       <= done_next;
      timeout    <= timeout_next;
      sum_cycles <= sum_next;
      min_cycles <= min_next;
      max_cycles <= max_next;
    end
  end

endmodule

// File: tb/tb_spy_path_delay_meter.sv
// Self-checking bench: a trial-level reference model for the default instance, checked every
// cycle, plus directed literal expectations for the default, inverting and narrow-sum instances.
module tb_spy_path_delay_meter;

  localparam int TMO     = 4000;
  localparam int SYNC    = 2;
  localparam int R       = 4;
  localparam int SUM_MAX = (1 << 20) - 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Default instance (a) and its chain model
  logic        start_a, pi_a, pr_a, pr_del, pr_pre_a, busy_a, done_a, to_a;
  logic [7:0]  trials_a;
  logic [19:0] sum_a;
  logic [11:0] min_a, max_a;
  int          chain_mode;   // 0 = zero delay, 1 = 37 ns transport delay, 2 = stuck at 0

  // Inverting instance (b) and narrow-sum instance (c), both with zero-delay chains
  logic        start_b, pi_b, pr_b, busy_b, done_b, to_b;
  logic [7:0]  trials_b;
  logic [19:0] sum_b;
  logic [11:0] min_b, max_b;
  logic        start_c, pi_c, pr_c, busy_c, done_c, to_c;
  logic [7:0]  trials_c;
  logic [3:0]  sum_c;
  logic [11:0] min_c, max_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(pi_a) pr_del <= #37 pi_a;
  assign pr_a = (chain_mode == 0) ? pi_a : ((chain_mode == 1) ? pr_del : 1'b0);
  assign pr_b = ~pi_b;
  assign pr_c = pi_c;

  spy_path_delay_meter dut_a (
    .clk(clk), .rst(rst), .start(start_a), .trials(trials_a), .pathInput(pi_a),
    .pathResult(pr_a), .busy(busy_a), .done(done_a), .timeout(to_a),
    .sum_cycles(sum_a), .min_cycles(min_a), .max_cycles(max_a)
  );

  spy_path_delay_meter #(.INVERT(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .trials(trials_b), .pathInput(pi_b),
    .pathResult(pr_b), .busy(busy_b), .done(done_b), .timeout(to_b),
    .sum_cycles(sum_b), .min_cycles(min_b), .max_cycles(max_b)
  );

  spy_path_delay_meter #(.SUM_W(4)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .trials(trials_c), .pathInput(pi_c),
    .pathResult(pr_c), .busy(busy_c), .done(done_c), .timeout(to_c),
    .sum_cycles(sum_c), .min_cycles(min_c), .max_cycles(max_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Chain output as the DUT flops will see it: sampled just before each rising edge.
  always @(negedge clk) begin
    #4;
    pr_pre_a <= pr_a;
  end

  // Reference model for dut_a: a trial ends on the first edge at which the chain output,
  // seen SYNC edges late, shows the new target level; counts are edges since the launch edge.
  logic ring [0:R-1];
  int   e_cnt, age, left, m_sum, m_min, m_max;
  logic m_pi, m_busy, m_done, m_to, tgt;
  bit   launch_next, in_trial;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < R; i++) ring[i] <= 1'b0;
      e_cnt <= 0; age <= 0; left <= 0; tgt <= 1'b0;
      m_pi <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_to <= 1'b0;
      m_sum <= 0; m_min <= 4095; m_max <= 0;
      launch_next <= 1'b0; in_trial <= 1'b0;
    end else begin
      automatic logic seen = ring[(e_cnt + R - SYNC) % R];
      automatic int   n    = age + 1;
      ring[e_cnt % R] <= pr_pre_a;
      e_cnt <= e_cnt + 1;
      if (m_done) begin
        m_done <= 1'b0;
        m_busy <= 1'b0;
      end else if (launch_next) begin
        launch_next <= 1'b0;
        in_trial    <= 1'b1;
        age         <= 0;
        m_pi        <= ~m_pi;
        tgt         <= ~m_pi;
      end else if (in_trial) begin
        age <= n;
        if (seen == tgt) begin
          m_sum <= (m_sum + n > SUM_MAX) ? SUM_MAX : m_sum + n;
          if (n < m_min) m_min <= n;
          if (n > m_max) m_max <= n;
          left     <= left - 1;
          in_trial <= 1'b0;
          if (left == 1) m_done <= 1'b1;
          else           launch_next <= 1'b1;
        end else if (n == TMO) begin
          m_to     <= 1'b1;
          in_trial <= 1'b0;
          m_done   <= 1'b1;
        end
      end else if (!m_busy && start_a) begin
        m_busy <= 1'b1;
        left   <= trials_a;
        m_sum  <= 0; m_min <= 4095; m_max <= 0; m_to <= 1'b0;
        if (trials_a == 8'd0) m_done <= 1'b1;
        else                  launch_next <= 1'b1;
      end
    end
  end

  // Every-cycle comparison of dut_a against the model.
  always @(negedge clk) begin
    check("cyc_busy", busy_a, m_busy);
    check("cyc_done", done_a, m_done);
    check("cyc_pathInput", pi_a, m_pi);
    check("cyc_timeout", to_a, m_to);
    check("cyc_sum", sum_a, m_sum);
    check("cyc_min", min_a, m_min);
    check("cyc_max", max_a, m_max);
  end

  int done_cnt_a = 0;
  int busy_cnt_a = 0;
  // Count done pulses and busy cycles of dut_a.
  always @(negedge clk) begin
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
  end

  task automatic start_run_a(input logic [7:0] n, output int k);
    @(posedge clk); #1;
    start_a  = 1'b1;
    trials_a = n;
    k        = cyc;
    @(posedge clk); #1;
    start_a  = 1'b0;
    trials_a = 8'd0;
  endtask

  task automatic wait_done_a(input int limit, output bit ok, output int dc);
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_a) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, dc, d0, b0;
    bit  ok;
    chain_mode = 0;
    start_a = 1'b0; trials_a = 8'd0;
    start_b = 1'b0; trials_b = 8'd0;
    start_c = 1'b0; trials_c = 8'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    check("rst_sum", sum_a, 32'd0);
    check("rst_min", min_a, 32'd4095);
    check("rst_max", max_a, 32'd0);
    check("rst_busy", busy_a, 32'd0);
    check("rst_pi", pi_a, 32'd0);
    check("rst_pi_inv", pi_b, 32'd0);

    // Zero-delay chain, 4 trials: every count is SYNC+1 = 3; start cycle to done cycle
    // spans 1 + 4*(3+1) + 1 = 18 cycles inclusive, so done is 17 cycles after the start cycle.
    d0 = done_cnt_a;
    start_run_a(8'd4, k);
    wait_done_a(200, ok, dc);
    check("zero_done_seen", ok, 32'd1);
    check("zero_latency", dc - k, 32'd17);
    repeat (2) @(negedge clk);
    check("zero_sum", sum_a, 32'd12);
    check("zero_min", min_a, 32'd3);
    check("zero_max", max_a, 32'd3);
    check("zero_done_once", done_cnt_a - d0, 32'd1);
    check("model_zero_sum", m_sum, 32'd12);

    // 37 ns transport delay at 10 ns clock, 8 trials
    chain_mode = 1;
    start_run_a(8'd8, k);
    wait_done_a(400, ok, dc);
    check("dly_done_seen", ok, 32'd1);
    repeat (2) @(negedge clk);
    check("dly_min_ge6", (min_a >= 12'd6), 32'd1);
    check("dly_max_le7", (max_a <= 12'd7), 32'd1);
    check("dly_sum_ge48", (sum_a >= 20'd48), 32'd1);
    check("dly_sum_le56", (sum_a <= 20'd56), 32'd1);
    check("model_dly_sum_ge48", (m_sum >= 48), 32'd1);

    // Stuck-at-0 chain, 3 trials: first trial waits for a 1 and times out
    chain_mode = 2;
    d0 = done_cnt_a;
    start_run_a(8'd3, k);
    wait_done_a(TMO + 100, ok, dc);
    check("tmo_done_seen", ok, 32'd1);
    check("tmo_latency", dc - k, TMO + 2);
    check("tmo_flag", to_a, 32'd1);
    check("tmo_sum", sum_a, 32'd0);
    repeat (2) @(negedge clk);
    check("tmo_done_once", done_cnt_a - d0, 32'd1);
    check("tmo_flag_sticky", to_a, 32'd1);
    chain_mode = 0;
    repeat (4) @(posedge clk);
    start_run_a(8'd1, k);
    check("tmo_cleared", to_a, 32'd0);
    wait_done_a(100, ok, dc);
    check("tmo_rerun_done", ok, 32'd1);
    repeat (2) @(negedge clk);
    check("tmo_rerun_sum", sum_a, 32'd3);

    // trials=0: done in the next cycle, one busy cycle, no toggle (pathInput is 0 here)
    d0 = done_cnt_a;
    b0 = busy_cnt_a;
    start_run_a(8'd0, k);
    wait_done_a(20, ok, dc);
    check("t0_latency", dc - k, 32'd1);
    repeat (3) @(negedge clk);
    check("t0_busy_cycles", busy_cnt_a - b0, 32'd1);
    check("t0_done_once", done_cnt_a - d0, 32'd1);
    check("t0_pi", pi_a, 32'd0);

    // Start while busy is ignored: 2 trials stay 2 trials
    d0 = done_cnt_a;
    start_run_a(8'd2, k);
    @(posedge clk); #1;
    start_a = 1'b1; trials_a = 8'd7;
    @(posedge clk); #1;
    start_a = 1'b0; trials_a = 8'd0;
    wait_done_a(100, ok, dc);
    check("busy_latency", dc - k, 32'd9);
    repeat (3) @(negedge clk);
    check("busy_sum", sum_a, 32'd6);
    check("busy_done_once", done_cnt_a - d0, 32'd1);

    // Reset during WAIT of trial 2 (LAUNCH at k+5, WAIT from k+6)
    d0 = done_cnt_a;
    start_run_a(8'd4, k);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_sum", sum_a, 32'd0);
    check("mid_rst_min", min_a, 32'd4095);
    check("mid_rst_max", max_a, 32'd0);
    check("mid_rst_busy", busy_a, 32'd0);
    check("mid_rst_done", done_a, 32'd0);
    check("mid_rst_pi", pi_a, 32'd0);
    check("mid_rst_to", to_a, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_no_done", done_cnt_a - d0, 32'd0);
    start_run_a(8'd2, k);
    wait_done_a(100, ok, dc);
    check("post_rst_latency", dc - k, 32'd9);
    repeat (2) @(negedge clk);
    check("post_rst_sum", sum_a, 32'd6);

    // Inverting chain, 2 trials
    @(posedge clk); #1;
    start_b = 1'b1; trials_b = 8'd2;
    @(posedge clk); #1;
    start_b = 1'b0; trials_b = 8'd0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_b) begin
        ok = 1'b1;
        break;
      end
    end
    check("inv_done_seen", ok, 32'd1);
    check("inv_sum", sum_b, 32'd6);
    check("inv_min", min_b, 32'd3);
    check("inv_max", max_b, 32'd3);
    check("inv_pi", pi_b, 32'd0);
    check("inv_to", to_b, 32'd0);

    // 4-bit sum, 8 zero-delay trials: 8*3 = 24 saturates at 15
    @(posedge clk); #1;
    start_c = 1'b1; trials_c = 8'd8;
    @(posedge clk); #1;
    start_c = 1'b0; trials_c = 8'd0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_c) begin
        ok = 1'b1;
        break;
      end
    end
    check("sat_done_seen", ok, 32'd1);
    check("sat_sum", sum_c, 32'd15);
    check("sat_min", min_c, 32'd3);
    check("sat_max", max_c, 32'd3);
    check("sat_busy_dsp", busy_c, 32'd1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
